// File: rtl/dac_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dac_stream_ctrl
// Brief    : Ticked, slew-limited sample sequencer for the 8-bit R-2R DAC,
//            with a 2-entry input FIFO and a click-free mute ramp to midscale.
// Revision : 1.0 - initial release
// ============================================================================
module dac_stream_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic             mute,
    input  logic [7:0]       slew_max,
    output logic [7:0]       dac_d,
    output logic             tick_out,
    output logic             underrun,
    output logic             muted
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RAMP_DN = 2'd1,
        S_MUTED   = 2'd2
    } state_t;

    localparam logic [7:0]       C_MID = 8'h80;
    localparam logic [DIV_W-1:0] C_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Moves cur towards tgt by at most s (s==0: jump straight to tgt).
    function automatic logic [7:0] step_code(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] s);
        logic [8:0] d;
        logic [8:0] mag;
        d   = {1'b0, tgt} - {1'b0, cur};
        mag = d[8] ? (9'd0 - d) : d;
        if ((s == 8'd0) || (mag <= {1'b0, s}))
            step_code = tgt;
        else if (d[8])
            step_code = cur - s;
        else
            step_code = cur + s;
    endfunction

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [7:0]       r_target;
    logic [7:0]       r_dac;
    logic             r_tick_out;
    logic             r_underrun;

    logic       w_tick;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;
    logic [7:0] w_ramp_slew;
    logic [7:0] w_run_step;
    logic [7:0] w_ramp_step;
    logic [7:0] w_ramp_final;

    assign w_tick       = (r_cnt == '0);
    assign s_ready      = (r_count != 2'd2);
    assign w_push       = s_valid && s_ready;
    assign w_pop        = w_tick && (r_count != 2'd0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_ramp_slew  = (slew_max == 8'd0) ? 8'd1 : slew_max;
    assign w_run_step   = step_code(r_dac, w_pop ? w_head : r_target, slew_max);
    assign w_ramp_step  = step_code(r_dac, C_MID, w_ramp_slew);
    assign w_ramp_final = w_tick ? w_ramp_step : r_dac;

    // Storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_MUTED;
            r_cnt      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_target   <= C_MID;
            r_dac      <= C_MID;
            r_tick_out <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tick_out <= w_tick;
            r_underrun <= 1'b0;
            r_cnt      <= w_tick ? div : (r_cnt - C_ONE);
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        r_dac <= w_run_step;
                        if (w_pop)
                            r_target <= w_head;
                        else
                            r_underrun <= 1'b1;
                    end
                    if (mute)
                        r_state <= S_RAMP_DN;
                end
                S_RAMP_DN: begin
                    r_target <= C_MID;
                    if (w_tick)
                        r_dac <= w_ramp_step;
                    if (!mute)
                        r_state <= S_RUN;
                    else if (w_ramp_final == C_MID)
                        r_state <= S_MUTED;
                end
                S_MUTED: begin
                    r_target <= C_MID;
                    r_dac    <= C_MID;
                    if (!mute)
                        r_state <= S_RUN;
                end
                default: r_state <= S_MUTED;
            endcase
        end
    end

    assign dac_d    = r_dac;
    assign tick_out = r_tick_out;
    assign underrun = r_underrun;
    assign muted    = (r_state == S_MUTED);

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_stream_ctrl
// Brief    : Directed scoreboard bench for dac_stream_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] div;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       mute;
    logic [7:0] slew_max;
    logic [7:0] dac_d;
    logic       tick_out;
    logic       underrun;
    logic       muted;

    dac_stream_ctrl #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .div      (div),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mute     (mute),
        .slew_max (slew_max),
        .dac_d    (dac_d),
        .tick_out (tick_out),
        .underrun (underrun),
        .muted    (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dac;
        logic       und;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic u, input string t);
        exp_t e;
        e.dac = d;
        e.und = u;
        e.tag = t;
        return e;
    endfunction

    // One clock; every tick_out while monitoring pops one scoreboard entry.
    task automatic step_clk();
        exp_t e;
        @(negedge clk);
        if (mon_en && tick_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_tick observed dac_d=%0h with no expectation queued", dac_d);
            end else begin
                e = q.pop_front();
                chk({e.tag, "_dac"}, 32'(dac_d), 32'(e.dac));
                chk({e.tag, "_und"}, 32'(underrun), 32'(e.und));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            step_clk();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic push(input logic [7:0] d);
        chk("push_ready", 32'(s_ready), 32'd1);
        s_data  = d;
        s_valid = 1'b1;
        step_clk();
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit low_ok;

        rst = 1'b1; div = 8'd3; s_valid = 1'b0; s_data = 8'h00;
        mute = 1'b0; slew_max = 8'd0;
        repeat (3) step_clk();
        chk("rst_dac", 32'(dac_d), 32'h80);
        chk("rst_tick_out", 32'(tick_out), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_muted", 32'(muted), 32'd1);
        chk("rst_ready", 32'(s_ready), 32'd1);

        // Release: first tick lands in the first cycle, MUTED -> RUN.
        rst = 1'b0;
        n = 0;
        do begin step_clk(); n++; end while (!tick_out && n < 20);
        chk("first_tick_latency", 32'(n), 32'd1);
        chk("run_after_release", 32'(muted), 32'd0);

        mon_en = 1'b1;
        q.push_back(mk(8'h10, 1'b0, "first_sample"));
        push(8'h10);
        drain();
        q.push_back(mk(8'h10, 1'b1, "hold_underrun"));
        n = 0;
        do begin step_clk(); n++; end while (!tick_out && n < 20);
        chk("tick_period_div3", 32'(n), 32'd4);

        // Slew-limited climb.
        q.push_back(mk(8'h80, 1'b0, "to_mid"));
        push(8'h80);
        drain();
        slew_max = 8'h20;
        q.push_back(mk(8'hA0, 1'b0, "slew1"));
        q.push_back(mk(8'hC0, 1'b1, "slew2"));
        q.push_back(mk(8'hE0, 1'b1, "slew3"));
        q.push_back(mk(8'hF0, 1'b1, "slew4"));
        push(8'hF0);
        drain();

        // Backpressure with div=7, applied at the next reload.
        div = 8'd7;
        q.push_back(mk(8'hF0, 1'b1, "reload"));
        drain();
        slew_max = 8'd0;
        q.push_back(mk(8'hA1, 1'b0, "bp1"));
        q.push_back(mk(8'hA2, 1'b0, "bp2"));
        q.push_back(mk(8'hA3, 1'b0, "bp3"));
        s_data = 8'hA1; s_valid = 1'b1;
        chk("bp_ready0", 32'(s_ready), 32'd1);
        step_clk();
        s_data = 8'hA2;
        chk("bp_ready1", 32'(s_ready), 32'd1);
        step_clk();
        chk("bp_full", 32'(s_ready), 32'd0);
        s_data = 8'hA3;
        n = 0; low_ok = 1'b1;
        do begin
            step_clk();
            n++;
            if (!tick_out && s_ready) low_ok = 1'b0;
        end while (!tick_out && n < 20);
        chk("bp_wait_cycles", 32'(n), 32'd6);
        chk("bp_ready_low_until_pop", 32'(low_ok), 32'd1);
        chk("bp_ready_after_pop", 32'(s_ready), 32'd1);
        step_clk();
        s_valid = 1'b0;
        drain();

        // Mute ramp, then pushes consumed silently while muted.
        q.push_back(mk(8'h84, 1'b0, "pre_mute"));
        push(8'h84);
        drain();
        mute = 1'b1;
        q.push_back(mk(8'h83, 1'b0, "ramp1"));
        q.push_back(mk(8'h82, 1'b0, "ramp2"));
        q.push_back(mk(8'h81, 1'b0, "ramp3"));
        q.push_back(mk(8'h80, 1'b0, "ramp4"));
        drain();
        chk("muted_after_ramp", 32'(muted), 32'd1);
        q.push_back(mk(8'h80, 1'b0, "mute_pop1"));
        q.push_back(mk(8'h80, 1'b0, "mute_pop2"));
        q.push_back(mk(8'h80, 1'b0, "mute_empty"));
        push(8'h55);
        push(8'h66);
        drain();
        chk("still_muted", 32'(muted), 32'd1);
        chk("mute_fifo_drained", 32'(s_ready), 32'd1);

        // Unmute mid-ramp.
        mute = 1'b0;
        slew_max = 8'd4;
        q.push_back(mk(8'h84, 1'b0, "up1"));
        q.push_back(mk(8'h88, 1'b1, "up2"));
        q.push_back(mk(8'h8C, 1'b1, "up3"));
        q.push_back(mk(8'h90, 1'b1, "up4"));
        push(8'h90);
        drain();
        chk("unmuted", 32'(muted), 32'd0);
        mute = 1'b1;
        q.push_back(mk(8'h8C, 1'b0, "dn1"));
        q.push_back(mk(8'h88, 1'b0, "dn2"));
        drain();
        mute = 1'b0;
        q.push_back(mk(8'h84, 1'b1, "resume1"));
        q.push_back(mk(8'h80, 1'b1, "resume2"));
        drain();
        chk("run_after_unmute", 32'(muted), 32'd0);
        q.push_back(mk(8'h7C, 1'b0, "zero1"));
        q.push_back(mk(8'h78, 1'b1, "zero2"));
        push(8'h00);
        drain();

        // Reset mid-ramp with a sample still queued.
        slew_max = 8'd0;
        q.push_back(mk(8'hA0, 1'b0, "pre_rst"));
        push(8'hA0);
        drain();
        mute = 1'b1;
        slew_max = 8'd4;
        push(8'h33);
        step_clk();
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_dac", 32'(dac_d), 32'h80);
        chk("async_rst_ready", 32'(s_ready), 32'd1);
        chk("async_rst_muted", 32'(muted), 32'd1);
        chk("async_rst_tick_out", 32'(tick_out), 32'd0);
        chk("async_rst_underrun", 32'(underrun), 32'd0);
        step_clk();
        step_clk();
        chk("rst_hold_dac", 32'(dac_d), 32'h80);
        mute = 1'b0; slew_max = 8'd0; div = 8'd3;
        rst = 1'b0;
        mon_en = 1'b1;
        q.push_back(mk(8'h80, 1'b0, "post_rst_tick"));
        q.push_back(mk(8'h80, 1'b1, "post_rst_empty"));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
